// File: rtl/snake_pkg.sv
// Shared definitions for the snake datapath back end: default word/FIFO sizes,
// the word type and an even-parity helper.
// Optional feature macro used by this slice: SNAKE_PACK_PARITY_EN.
package snake_pkg;

  localparam int unsigned SNAKE_WORD_W     = 8;
  localparam int unsigned SNAKE_FIFO_DEPTH = 4;

  // Widest word the parity helper accepts; narrower words are zero-extended.
  localparam int unsigned SNAKE_PAR_MAX_W  = 64;

  typedef logic [SNAKE_WORD_W-1:0] snake_word_t;

  // Even parity bit: set when the word holds an odd number of ones, so that
  // {par, word} always carries an even number of ones.
  function automatic logic snake_par(input logic [SNAKE_PAR_MAX_W-1:0] w);
    return ^w;
  endfunction

endpackage

// File: rtl/snake_sync_fifo.sv
// Synchronous FIFO with a registered head word, explicit occupancy counter and
// a same-edge push/pop pass-through when full. Used by snake_bit_packer.
// Data width is widened by one bit by the parent when SNAKE_PACK_PARITY_EN is set.
module snake_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_data,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_head,
  output logic                   o_vld,
  output logic [$clog2(DEPTH):0] o_fill,
  output logic                   o_drop_c
);

  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned FILL_W = PTR_W + 1;

  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [FILL_W-1:0] r_fill;
  logic [WIDTH-1:0]  r_head;
  logic              r_vld;

  logic              w_full;
  logic              w_do_pop;
  logic              w_do_push;
  logic [PTR_W-1:0]  w_rd_ptr_nxt;
  logic [FILL_W-1:0] w_remain;
  logic [FILL_W-1:0] w_fill_nxt;
  logic [WIDTH-1:0]  w_head_nxt;

  assign w_full       = (r_fill == FILL_W'(DEPTH));
  assign w_do_pop     = i_pop && r_vld;
  // A pop on the same edge frees the slot a full FIFO needs for the push.
  assign w_do_push    = i_push && (!w_full || w_do_pop);
  assign o_drop_c     = i_push && w_full && !w_do_pop;
  assign w_rd_ptr_nxt = r_rd_ptr + PTR_W'(w_do_pop);
  assign w_remain     = r_fill - FILL_W'(w_do_pop);
  assign w_fill_nxt   = w_remain + FILL_W'(w_do_push);

  // Next head: the pushed word if nothing older survives this edge, otherwise
  // the stored entry at the advanced read pointer; zero while empty.
  always_comb begin
    w_head_nxt = '0;
    if (w_fill_nxt != '0) begin
      if (w_remain == '0) begin
        w_head_nxt = i_data;
      end else begin
        w_head_nxt = r_mem[w_rd_ptr_nxt];
      end
    end
  end

  // Storage array write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointers, occupancy and the registered head/valid pair.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_fill   <= '0;
      r_head   <= '0;
      r_vld    <= 1'b0;
    end else begin
      r_wr_ptr <= r_wr_ptr + PTR_W'(w_do_push);
      r_rd_ptr <= w_rd_ptr_nxt;
      r_fill   <= w_fill_nxt;
      r_head   <= w_head_nxt;
      r_vld    <= (w_fill_nxt != '0);
    end
  end

  assign o_head = r_head;
  assign o_vld  = r_vld;
  assign o_fill = r_fill;

endmodule

// File: rtl/snake_bit_packer.sv
// Packs the snake netlist's serial out1 stream LSB-first into WIDTH-bit words
// and offers them to the host through a small FIFO with valid/ready handshake.
// Overflow (a completed word that found the FIFO full) sets a sticky flag.
// Optional feature: SNAKE_PACK_PARITY_EN adds an even-parity bit per word (word_par).
module snake_bit_packer
  import snake_pkg::*;
#(
  parameter int unsigned WIDTH = SNAKE_WORD_W,
  parameter int unsigned DEPTH = SNAKE_FIFO_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   bit_in,
  input  logic                   bit_vld,
  input  logic                   flush,
  output logic [WIDTH-1:0]       word_o,
  output logic                   word_vld,
  input  logic                   word_rdy,
  output logic [$clog2(DEPTH):0] fill,
  output logic [$clog2(WIDTH)-1:0] bit_cnt,
  output logic                   ovf
`ifdef SNAKE_PACK_PARITY_EN
  ,
  output logic                   word_par
`endif
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
`ifdef SNAKE_PACK_PARITY_EN
  localparam int unsigned FIFO_W = WIDTH + 1;
`else
  localparam int unsigned FIFO_W = WIDTH;
`endif

  logic [CNT_W-1:0]  r_bit_cnt;
  logic [WIDTH-2:0]  r_shift;
  logic              r_ovf;

  logic              w_last;
  logic              w_push;
  logic              w_drop;
  logic [WIDTH-1:0]  w_word;
  logic [WIDTH-2:0]  w_shift_nxt;
  logic [FIFO_W-1:0] w_fifo_din;
  logic [FIFO_W-1:0] w_fifo_head;

  assign w_last = (r_bit_cnt == CNT_W'(WIDTH - 1));
  // flush wins over a completing bit: that word is never pushed.
  assign w_push = bit_vld && !flush && w_last;
  // The final bit goes straight into the MSB; it is never stored in r_shift.
  assign w_word = {bit_in, r_shift};

`ifdef SNAKE_PACK_PARITY_EN
  assign w_fifo_din = {snake_par(SNAKE_PAR_MAX_W'(w_word)), w_word};
  assign word_par   = w_fifo_head[WIDTH];
`else
  assign w_fifo_din = w_word;
`endif

  // Place the incoming bit at the current fill position of the partial word.
  always_comb begin
    w_shift_nxt = r_shift;
    for (int i = 0; i < int'(WIDTH) - 1; i++) begin
      if (r_bit_cnt == CNT_W'(i)) begin
        w_shift_nxt[i] = bit_in;
      end
    end
  end

  // Partial-word accumulator; bit_cnt doubles as the packing state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bit_cnt <= '0;
      r_shift   <= '0;
    end else if (flush) begin
      r_bit_cnt <= '0;
      r_shift   <= '0;
    end else if (bit_vld) begin
      r_shift   <= w_shift_nxt;
      r_bit_cnt <= w_last ? '0 : r_bit_cnt + CNT_W'(1);
    end
  end

  // Sticky overflow flag, cleared only by flush or reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (flush) begin
      r_ovf <= 1'b0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
    end
  end

  snake_sync_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_push   (w_push),
    .i_data   (w_fifo_din),
    .i_pop    (word_rdy),
    .o_head   (w_fifo_head),
    .o_vld    (word_vld),
    .o_fill   (fill),
    .o_drop_c (w_drop)
  );

  assign word_o  = w_fifo_head[WIDTH-1:0];
  assign bit_cnt = r_bit_cnt;
  assign ovf     = r_ovf;

endmodule
